// File: rtl/tile_scanout.sv
// Display read stage: VGA timing, tile address generation, 2-clock pixel pipeline, buffer swap at vertical blank.
// Optional white tile grid overlay is enabled by defining TILE_SCANOUT_GRID_LINES_EN.
module tile_scanout #(
  parameter int A          = 9,
  parameter int S          = 24,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TILE_SHIFT = 5,
  parameter int GRID_W     = 20
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         frame_done,
  output logic [A-1:0] address_read,
  input  logic [S-1:0] data_read,
  output logic         swap,
  output logic         swap_ack,
  output logic [S-1:0] rgb,
  output logic         de,
  output logic         hsync,
  output logic         vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [VW-1:0] vcnt_reg, vcnt_next;
  logic          pending_reg, pending_next;
  logic          active, hs_raw, vs_raw, at_swap, fire;
  logic          active_d1_reg, hs_d1_reg, vs_d1_reg;

  always_comb begin
    hcnt_next = hcnt_reg + 1'b1;
    vcnt_next = vcnt_reg;
    if (hcnt_reg == HW'(H_TOTAL - 1)) begin
      hcnt_next = '0;
      vcnt_next = (vcnt_reg == VW'(V_TOTAL - 1)) ? '0 : vcnt_reg + 1'b1;
    end
  end

  assign active = (hcnt_reg < HW'(H_ACTIVE)) && (vcnt_reg < VW'(V_ACTIVE));
  assign hs_raw = (hcnt_reg >= HW'(H_ACTIVE + H_FP)) &&
                  (hcnt_reg <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign vs_raw = (vcnt_reg >= VW'(V_ACTIVE + V_FP)) &&
                  (vcnt_reg <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

  // Row*width product is formed at 32 bits, then truncated to the port width.
  assign address_read = active
      ? A'(32'(vcnt_reg >> TILE_SHIFT) * 32'(GRID_W) + 32'(hcnt_reg >> TILE_SHIFT))
      : '0;

  // Swap lands on the last cycle of the last visible line, after all active reads issued.
  assign at_swap  = (hcnt_reg == HW'(H_TOTAL - 1)) && (vcnt_reg == VW'(V_ACTIVE - 1));
  assign fire     = at_swap && (pending_reg || frame_done);
  assign swap     = fire;
  assign swap_ack = fire;

  always_comb begin
    pending_next = pending_reg | frame_done;
    if (fire) pending_next = 1'b0;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hcnt_reg    <= '0;
      vcnt_reg    <= '0;
      pending_reg <= 1'b0;
    end else begin
      hcnt_reg    <= hcnt_next;
      vcnt_reg    <= vcnt_next;
      pending_reg <= pending_next;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      active_d1_reg <= 1'b0;
      hs_d1_reg     <= 1'b0;
      vs_d1_reg     <= 1'b0;
    end else begin
      active_d1_reg <= active;
      hs_d1_reg     <= hs_raw;
      vs_d1_reg     <= vs_raw;
    end
  end

`ifdef TILE_SCANOUT_GRID_LINES_EN
  logic edge_d1_reg;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      edge_d1_reg <= 1'b0;
    end else begin
      edge_d1_reg <= (hcnt_reg[TILE_SHIFT-1:0] == '0) || (vcnt_reg[TILE_SHIFT-1:0] == '0);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rgb <= '0;
    end else if (!active_d1_reg) begin
      rgb <= '0;
    end else begin
      rgb <= edge_d1_reg ? {S{1'b1}} : data_read;
    end
  end
`else
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rgb <= '0;
    end else begin
      rgb <= active_d1_reg ? data_read : '0;
    end
  end
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      de    <= active_d1_reg;
      hsync <= ~hs_d1_reg;
      vsync <= ~vs_d1_reg;
    end
  end

endmodule

// File: tb/tb_tile_scanout.sv
// Scoreboard bench for tile_scanout on a reduced raster, with a two-bank random tile memory.
// Define TILE_SCANOUT_GRID_LINES_EN for both bench and RTL to exercise the grid overlay.
module tb_tile_scanout;
  localparam int A   = 9;
  localparam int S   = 24;
  localparam int HA  = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA  = 32, VFP = 2, VS = 2, VBP = 2;
  localparam int TS  = 3;
  localparam int T   = 1 << TS;
  localparam int GW  = HA / T;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic         clock = 0;
  logic         nreset = 0;
  logic         frame_done = 0;
  logic [A-1:0] address_read;
  logic [S-1:0] data_read = '0;
  logic         swap, swap_ack, de, hsync, vsync;
  logic [S-1:0] rgb;

  tile_scanout #(
    .A(A), .S(S), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .TILE_SHIFT(TS), .GRID_W(GW)
  ) dut (
    .clock(clock), .nreset(nreset), .frame_done(frame_done),
    .address_read(address_read), .data_read(data_read),
    .swap(swap), .swap_ack(swap_ack), .rgb(rgb), .de(de),
    .hsync(hsync), .vsync(vsync)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Two-bank tile memory: one-clock read latency, bank flips on the DUT swap.
  logic [S-1:0] mem [2][1 << A];
  logic         mbank = 0;
  always @(posedge clock) begin
    data_read <= mem[mbank][address_read];
    if (swap) mbank <= ~mbank;
  end

  int swap_cnt = 0;
  always @(negedge clock) if (nreset && swap) swap_cnt++;

  // Reference model: pixel index since reset release -> raster position -> expected pins.
  typedef struct packed { logic [S-1:0] rgb; logic de; logic hs; logic vs; } pix_t;
  typedef struct packed { logic [A-1:0] addr; logic sw; } ctl_t;
  pix_t pq[$];
  ctl_t cq[$];
  int   p = 0;
  bit   pend = 0;
  bit   ebank = 0;

  function automatic int cur_h(); return p % HT; endfunction
  function automatic int cur_v(); return (p / HT) % VT; endfunction

  always @(negedge clock) begin
    if (!nreset) begin
      p = 0;
      pend = 0;
      pq.delete();
      cq.delete();
    end else begin
      int h, v, addr;
      bit act, hs, vs, sw;
      pix_t e;
      h    = p % HT;
      v    = (p / HT) % VT;
      act  = (h < HA) && (v < VA);
      addr = act ? (v / T) * GW + (h / T) : 0;
      hs   = (h >= HA + HFP) && (h < HA + HFP + HS);
      vs   = (v >= VA + VFP) && (v < VA + VFP + VS);
      e.rgb = act ? mem[ebank][addr] : '0;
`ifdef TILE_SCANOUT_GRID_LINES_EN
      if (act && ((h % T) == 0 || (v % T) == 0)) e.rgb = 24'hFFFFFF;
`endif
      e.de = act;
      e.hs = ~hs;
      e.vs = ~vs;
      sw = (h == HT - 1) && (v == VA - 1) && (pend || frame_done);
      if (sw) begin
        pend  = 0;
        ebank = ~ebank;
      end else if (frame_done) begin
        pend = 1;
      end
      cq.push_back('{addr: A'(addr), sw: sw});
      pq.push_back(e);
      p++;
    end
  end

  // Monitor: control signals are same-cycle, pixel pins trail the raster by two clocks.
  always @(negedge clock) begin
    #1;
    if (nreset) begin
      if (cq.size() > 0) begin
        ctl_t c;
        c = cq.pop_front();
        check("address_read", 64'(address_read), 64'(c.addr));
        check("swap/swap_ack", {62'd0, swap, swap_ack}, {62'd0, c.sw, c.sw});
      end
      if (pq.size() >= 3) begin
        pix_t e;
        e = pq.pop_front();
        check("rgb/de/hsync/vsync", 64'({rgb, de, hsync, vsync}), 64'(e));
      end
    end
  end

  task automatic wait_pixel(input int h, input int v);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(posedge clock);
      #2;
      if (cur_h() == h && cur_v() == v) hit = 1;
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL wait_pixel timeout waiting for (%0d,%0d)", h, v);
    end
  endtask

  task automatic pulse_done();
    frame_done = 1;
    @(posedge clock);
    #2;
    frame_done = 0;
  endtask

  task automatic check_reset_pins(input string name);
    check(name, 64'({rgb, de, hsync, vsync, swap, swap_ack}),
          64'({24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic swaps_over_frame(input string name, input int expected);
    int c0;
    c0 = swap_cnt;
    wait_pixel(0, VA);
    check(name, 64'(swap_cnt - c0), 64'(expected));
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < (1 << A); i++) mem[b][i] = S'($urandom);

    repeat (3) @(posedge clock);
    #2;
    check_reset_pins("reset_state");
    check("reset_address", 64'(address_read), 64'd0);
    nreset = 1;

    // Two idle frames: no frame_done, no swap.
    swaps_over_frame("idle_frame0_swaps", 0);
    swaps_over_frame("idle_frame1_swaps", 0);

    // Single request mid-frame: one swap, then none.
    wait_pixel(int'($urandom_range(0, HT - 1)), 10);
    pulse_done();
    swaps_over_frame("single_req_swaps", 1);
    swaps_over_frame("single_req_next_swaps", 0);

    // Three requests in one frame collapse to one swap.
    wait_pixel(int'($urandom_range(0, HT - 1)), 3);
    pulse_done();
    wait_pixel(int'($urandom_range(0, HT - 1)), 12);
    pulse_done();
    wait_pixel(int'($urandom_range(0, HT - 1)), 20);
    pulse_done();
    swaps_over_frame("triple_req_swaps", 1);

    // Request exactly on the swap-point cycle.
    wait_pixel(HT - 1, VA - 1);
    frame_done = 1;
    #1;
    check("swap_on_swap_point", {62'd0, swap, swap_ack}, 64'd3);
    @(posedge clock);
    #2;
    frame_done = 0;
    swaps_over_frame("swap_point_next_swaps", 0);

    // Reset mid-frame with a pending request: request is lost.
    wait_pixel(5, 5);
    pulse_done();
    wait_pixel(30, 20);
    nreset = 0;
    #1;
    check_reset_pins("midframe_reset_pins");
    repeat (3) @(posedge clock);
    #1;
    check_reset_pins("reset_hold_pins");
    #1;
    nreset = 1;
    swaps_over_frame("after_reset_swaps", 0);

    // Random frame_done traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clock);
      #2;
      frame_done = ($urandom_range(0, 1999) == 0);
    end
    frame_done = 0;
    repeat (4) @(posedge clock);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
